// File: rtl/crossfade_mixer.sv
// crossfade_mixer: input gain stage, N-pipeline return mixer with per-pipeline
// gains and programmable crossfade, then output gain. One signed multiplier is
// time-shared between all products and scheduled by a small FSM.
// Build option: define CROSSFADE_MIXER_SOFT_CLIP_EN to apply a soft knee to the
// output-gain product before its final hard saturation.
module crossfade_mixer #(
  parameter int data_width = 16,
  parameter int gain_shift = 4,
  parameter int pipe_bits  = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic signed [data_width-1:0]          in_sample,
  input  logic                                  in_sample_valid,
  output logic signed [data_width-1:0]          in_sample_out,
  output logic                                  in_sample_ready,
  input  logic [(1<<pipe_bits)*data_width-1:0]  out_samples_in,
  input  logic                                  out_samples_valid,
  output logic signed [data_width-1:0]          out_sample,
  output logic                                  out_sample_ready,
  input  logic [data_width-1:0]                 data_in,
  input  logic                                  set_input_gain,
  input  logic                                  set_output_gain,
  input  logic                                  set_ramp_step,
  input  logic                                  switch_req,
  input  logic [pipe_bits-1:0]                  switch_target,
  output logic                                  switching,
  output logic [pipe_bits-1:0]                  current_pipeline
);
  localparam int n_pipes    = 1 << pipe_bits;
  localparam int frac_bits  = data_width - 1 - gain_shift;
  localparam int prod_width = 2 * data_width;
  localparam int acc_width  = data_width + pipe_bits + 1;
  localparam logic [data_width-1:0] one_lsb = {{(data_width-1){1'b0}}, 1'b1};
  localparam logic [data_width-1:0] unity   = one_lsb << frac_bits;
  localparam logic signed [prod_width-1:0] sat_max =
    prod_width'((longint'(1) << (data_width - 1)) - longint'(1));
  localparam logic signed [prod_width-1:0] sat_min = ~sat_max;

  typedef enum logic [2:0] {
    IDLE, IN_WAIT, IN_DONE, MAC, GAIN_LD, GAIN_WAIT, OUT_DONE, GAP
  } state_t;

  // Clamp a wide signed value into the sample range.
  function automatic logic signed [data_width-1:0] sat_dw(input logic signed [prod_width-1:0] x);
    if (x > sat_max) return sat_max[data_width-1:0];
    else if (x < sat_min) return sat_min[data_width-1:0];
    else return x[data_width-1:0];
  endfunction

  // Clamp the mix accumulator into the sample range.
  function automatic logic signed [data_width-1:0] sat_acc(input logic signed [acc_width-1:0] a);
    return sat_dw(prod_width'(a));
  endfunction

`ifdef CROSSFADE_MIXER_SOFT_CLIP_EN
  localparam logic signed [prod_width-1:0] knee = prod_width'(longint'(1) << (data_width - 2));

  // Compress magnitudes above the knee by 4:1, keeping the sign.
  function automatic logic signed [prod_width-1:0] soft_knee(input logic signed [prod_width-1:0] x);
    logic signed [prod_width-1:0] mag;
    logic signed [prod_width-1:0] bent;
    mag = x[prod_width-1] ? -x : x;
    if (mag > knee) begin
      bent = knee + ((mag - knee) >>> 2'd2);
      return x[prod_width-1] ? -bent : bent;
    end else begin
      return x;
    end
  endfunction
`endif

  state_t                         state;
  logic signed [data_width-1:0]   op_a;
  logic signed [data_width-1:0]   op_b;
  logic signed [data_width-1:0]   prod_hold;
  logic signed [acc_width-1:0]    acc;
  logic [pipe_bits-1:0]           mac_idx;
  logic signed [data_width-1:0]   input_gain;
  logic signed [data_width-1:0]   output_gain;
  logic [data_width-1:0]          ramp_step;
  logic [data_width-1:0]          pipe_gain [n_pipes];
  logic [data_width-1:0]          gain_next [n_pipes];
  logic                           pending;
  logic [pipe_bits-1:0]           pending_target;
  logic [pipe_bits-1:0]           fade_target;
  logic                           fade_done;
  logic                           take_input;
  logic                           start_fade;

  // Shared multiplier: full-width product, Q-format realignment, saturation.
  logic signed [prod_width-1:0]   mul_prod;
  logic signed [prod_width-1:0]   mul_shift;
  logic signed [data_width-1:0]   mul_sat;
  logic signed [data_width-1:0]   mul_final;

  assign mul_prod  = prod_width'(op_a) * prod_width'(op_b);
  assign mul_shift = mul_prod >>> frac_bits;
  assign mul_sat   = sat_dw(mul_shift);
`ifdef CROSSFADE_MIXER_SOFT_CLIP_EN
  assign mul_final = sat_dw(soft_knee(mul_shift));
`else
  assign mul_final = mul_sat;
`endif

  assign take_input = (state == IDLE) && in_sample_valid;
  assign start_fade = (state == IDLE) && !switching && pending;

  // Next ramp gains (target up, others down, clamped) and the completion test on current gains.
  always_comb begin
    fade_done = 1'b1;
    for (int i = 0; i < n_pipes; i++) begin
      if (i == int'(fade_target)) begin
        if (({1'b0, pipe_gain[i]} + {1'b0, ramp_step}) >= {1'b0, unity}) gain_next[i] = unity;
        else gain_next[i] = pipe_gain[i] + ramp_step;
        fade_done = fade_done & (pipe_gain[i] == unity);
      end else begin
        if (pipe_gain[i] <= ramp_step) gain_next[i] = '0;
        else gain_next[i] = pipe_gain[i] - ramp_step;
        fade_done = fade_done & (pipe_gain[i] == '0);
      end
    end
  end

  // Sequencer: schedules the shared multiplier for the input path and the mix/output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      op_a             <= '0;
      op_b             <= '0;
      prod_hold        <= '0;
      acc              <= '0;
      mac_idx          <= '0;
      in_sample_out    <= '0;
      in_sample_ready  <= 1'b0;
      out_sample       <= '0;
      out_sample_ready <= 1'b0;
    end else begin
      in_sample_ready  <= 1'b0;
      out_sample_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (in_sample_valid) begin
            op_a  <= in_sample;
            op_b  <= input_gain;
            state <= IN_WAIT;
          end else if (out_samples_valid) begin
            op_a    <= out_samples_in[data_width-1:0];
            op_b    <= pipe_gain[0];
            mac_idx <= pipe_bits'(1);
            acc     <= '0;
            state   <= MAC;
          end else begin
            state <= IDLE;
          end
        end
        IN_WAIT: begin
          prod_hold <= mul_sat;
          state     <= IN_DONE;
        end
        IN_DONE: begin
          in_sample_out   <= prod_hold;
          in_sample_ready <= 1'b1;
          state           <= GAP;
        end
        MAC: begin
          // Accumulate the product of the previous operands while loading the next pipe.
          acc     <= acc + acc_width'(mul_sat);
          op_a    <= out_samples_in[int'(mac_idx)*data_width +: data_width];
          op_b    <= pipe_gain[mac_idx];
          mac_idx <= mac_idx + pipe_bits'(1);
          if (mac_idx == '0) state <= GAIN_LD;
          else state <= MAC;
        end
        GAIN_LD: begin
          op_a  <= sat_acc(acc);
          op_b  <= output_gain;
          state <= GAIN_WAIT;
        end
        GAIN_WAIT: begin
          prod_hold <= mul_final;
          state     <= OUT_DONE;
        end
        OUT_DONE: begin
          out_sample       <= prod_hold;
          out_sample_ready <= 1'b1;
          state            <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Gain registers, one-deep switch request holding register and crossfade ramp.
  always_ff @(posedge clk) begin
    if (reset) begin
      input_gain       <= unity;
      output_gain      <= unity;
      ramp_step        <= unity >> 3'd7;
      for (int i = 0; i < n_pipes; i++) pipe_gain[i] <= (i == 0) ? unity : '0;
      switching        <= 1'b0;
      current_pipeline <= '0;
      pending          <= 1'b0;
      pending_target   <= '0;
      fade_target      <= '0;
    end else begin
      if (set_input_gain)  input_gain  <= data_in;
      if (set_output_gain) output_gain <= data_in;
      if (set_ramp_step)   ramp_step   <= (data_in == '0) ? one_lsb : data_in;

      // A request for the already-selected pipe is dropped only when no fade is running.
      if (switch_req && (switching || (switch_target != current_pipeline))) begin
        pending        <= 1'b1;
        pending_target <= switch_target;
      end else if (start_fade) begin
        pending <= 1'b0;
      end

      if (start_fade) begin
        switching   <= 1'b1;
        fade_target <= pending_target;
      end else if (take_input && switching) begin
        if (fade_done) begin
          switching        <= 1'b0;
          current_pipeline <= fade_target;
        end else begin
          for (int i = 0; i < n_pipes; i++) pipe_gain[i] <= gain_next[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_crossfade_mixer.sv
// Directed bench for crossfade_mixer: table of single-transaction vectors plus
// hand-written crossfade, arbitration and reset sequences.
module tb_crossfade_mixer;
  localparam int dw = 16;
  localparam int np = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [dw-1:0] in_sample;
  logic                 in_sample_valid;
  logic signed [dw-1:0] in_sample_out;
  logic                 in_sample_ready;
  logic [np*dw-1:0]     out_samples_in;
  logic                 out_samples_valid;
  logic signed [dw-1:0] out_sample;
  logic                 out_sample_ready;
  logic [dw-1:0]        data_in;
  logic                 set_input_gain;
  logic                 set_output_gain;
  logic                 set_ramp_step;
  logic                 switch_req;
  logic [1:0]           switch_target;
  logic                 switching;
  logic [1:0]           current_pipeline;

  int n_checks = 0;
  int n_fail   = 0;

  crossfade_mixer dut (
    .clk(clk), .reset(reset),
    .in_sample(in_sample), .in_sample_valid(in_sample_valid),
    .in_sample_out(in_sample_out), .in_sample_ready(in_sample_ready),
    .out_samples_in(out_samples_in), .out_samples_valid(out_samples_valid),
    .out_sample(out_sample), .out_sample_ready(out_sample_ready),
    .data_in(data_in), .set_input_gain(set_input_gain),
    .set_output_gain(set_output_gain), .set_ramp_step(set_ramp_step),
    .switch_req(switch_req), .switch_target(switch_target),
    .switching(switching), .current_pipeline(current_pipeline)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit is_out;
    int in_gain;
    int out_gain;
    int sample;
    int r0, r1, r2, r3;
    int raw;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [np*dw-1:0] pack(input int r0, input int r1, input int r2, input int r3);
    logic [np*dw-1:0] v;
    v[15:0]  = 16'(r0);
    v[31:16] = 16'(r1);
    v[47:32] = 16'(r2);
    v[63:48] = 16'(r3);
    return v;
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
  endfunction

  // Expected final output from the hand-computed realigned output-gain product.
  function automatic int out_fix(input int raw);
    int v;
    v = raw;
`ifdef CROSSFADE_MIXER_SOFT_CLIP_EN
    if (v > 16384) v = 16384 + ((v - 16384) >>> 2);
    else if (v < -16384) v = -(16384 + ((-v - 16384) >>> 2));
`endif
    return sat16(v);
  endfunction

  task automatic write_reg(input int which, input int value);
    data_in         = 16'(value);
    set_input_gain  = (which == 0);
    set_output_gain = (which == 1);
    set_ramp_step   = (which == 2);
    step();
    set_input_gain  = 1'b0;
    set_output_gain = 1'b0;
    set_ramp_step   = 1'b0;
  endtask

  task automatic request(input int target);
    switch_req    = 1'b1;
    switch_target = 2'(target);
    step();
    switch_req    = 1'b0;
  endtask

  // lat counts clock edges including the acceptance edge.
  task automatic run_in(input int s, output int res, output int lat);
    in_sample = 16'(s);
    in_sample_valid = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!in_sample_ready && lat < 40);
    res = int'(in_sample_out);
    if (!in_sample_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_timeout: no in_sample_ready within %0d cycles", lat);
    end
    in_sample_valid = 1'b0;
    step();
  endtask

  task automatic run_out(input logic [np*dw-1:0] rets, output int res, output int lat);
    out_samples_in = rets;
    out_samples_valid = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_sample_ready && lat < 40);
    res = int'(out_sample);
    if (!out_sample_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL out_timeout: no out_sample_ready within %0d cycles", lat);
    end
    out_samples_valid = 1'b0;
    step();
  endtask

  task automatic feed(input int count);
    int r, l;
    for (int k = 0; k < count; k++) run_in(0, r, l);
  endtask

  initial begin
    int res, lat, lat_in, lat_out, res_in, res_out, seen;

    vecs[0]  = '{1'b0, 2048, 2048, 1000, 0, 0, 0, 0, 1000};
    vecs[1]  = '{1'b0, 4096, 2048, 20000, 0, 0, 0, 0, 40000};
    vecs[2]  = '{1'b0, 4096, 2048, -20000, 0, 0, 0, 0, -40000};
    vecs[3]  = '{1'b0, 1024, 2048, -1000, 0, 0, 0, 0, -500};
    vecs[4]  = '{1'b0, 1, 2048, -3, 0, 0, 0, 0, -1};
    vecs[5]  = '{1'b0, 1, 2048, 3, 0, 0, 0, 0, 0};
    vecs[6]  = '{1'b1, 2048, 2048, 0, 1000, 2000, 3000, 4000, 1000};
    vecs[7]  = '{1'b1, 2048, 1024, 0, 1000, 2000, 3000, 4000, 500};
    vecs[8]  = '{1'b1, 2048, 4096, 0, 20000, 5, 5, 5, 40000};
    vecs[9]  = '{1'b1, 2048, 4096, 0, -20000, 5, 5, 5, -40000};
    vecs[10] = '{1'b1, 2048, 2048, 0, 32767, -32768, 5, 5, 32767};
    vecs[11] = '{1'b1, 2048, -2048, 0, 1000, 7, 7, 7, -1000};

    reset = 1'b1;
    in_sample = '0; in_sample_valid = 1'b0;
    out_samples_in = '0; out_samples_valid = 1'b0;
    data_in = '0; set_input_gain = 1'b0; set_output_gain = 1'b0; set_ramp_step = 1'b0;
    switch_req = 1'b0; switch_target = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    check("rst_in_sample_out", int'(in_sample_out), 0);
    check("rst_out_sample", int'(out_sample), 0);
    check("rst_in_ready", in_sample_ready, 0);
    check("rst_out_ready", out_sample_ready, 0);
    check("rst_switching", switching, 0);
    check("rst_current", current_pipeline, 0);

    // Single transactions; ready expected after edge e+2 (input) or e+7 (output).
    for (int i = 0; i < 12; i++) begin
      write_reg(0, vecs[i].in_gain);
      write_reg(1, vecs[i].out_gain);
      if (vecs[i].is_out) begin
        run_out(pack(vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].r3), res, lat);
        check($sformatf("vec%0d_out", i), res, out_fix(vecs[i].raw));
        check($sformatf("vec%0d_out_lat", i), lat, 8);
      end else begin
        run_in(vecs[i].sample, res, lat);
        check($sformatf("vec%0d_in", i), res, sat16(vecs[i].raw));
        check($sformatf("vec%0d_in_lat", i), lat, 3);
      end
    end
    write_reg(0, 2048);
    write_reg(1, 2048);

    // Fade 0 -> 2 with step 512: completes on the 5th accepted input sample.
    write_reg(2, 512);
    request(2);
    step();
    check("fadeA_started", switching, 1);
    feed(1);
    run_out(pack(1000, 0, 3000, 0), res, lat);
    check("fadeA_mix_1536_512", res, 1500);
    feed(3);
    check("fadeA_still_switching", switching, 1);
    run_out(pack(1000, 0, 3000, 0), res, lat);
    check("fadeA_mix_0_2048", res, 3000);
    feed(1);
    check("fadeA_done", switching, 0);
    check("fadeA_current", current_pipeline, 2);

    // Request for the already-selected pipe is ignored.
    request(2);
    step();
    check("same_target_ignored", switching, 0);

    // Fade 2 -> 0, sampled at the 1024/1024 midpoint, with a request to 1 queued mid-fade.
    request(0);
    step();
    feed(2);
    run_out(pack(30000, 30000, 30000, 30000), res, lat);
    check("mid_fade_30000", res, out_fix(30000));
    run_out(pack(32767, 32767, 32767, 32767), res, lat);
    check("mid_fade_32767", res, out_fix(32766));
    request(1);
    check("queued_keeps_fade", switching, 1);
    check("queued_current", current_pipeline, 2);
    feed(3);
    check("fadeB_done", switching, 0);
    check("fadeB_current", current_pipeline, 0);
    step();
    check("queued_started", switching, 1);
    feed(5);
    check("fadeC_done", switching, 0);
    check("fadeC_current", current_pipeline, 1);
    run_out(pack(0, 7000, 0, 0), res, lat);
    check("fadeC_mix", res, 7000);

    // Ramp step 0 is stored as 1: 2048 gain updates, completion on the next sample.
    write_reg(2, 0);
    request(3);
    step();
    feed(1024);
    run_out(pack(0, 2000, 0, 6000), res, lat);
    check("step1_midpoint_mix", res, 4000);
    feed(1024);
    check("step1_after_2048", switching, 1);
    feed(1);
    check("step1_done", switching, 0);
    check("step1_current", current_pipeline, 3);

    // Both sources valid: input first (ready after e+2), output accepted at e+4 (ready after e+11).
    in_sample = 16'(800);
    out_samples_in = pack(0, 0, 0, 1200);
    in_sample_valid = 1'b1;
    out_samples_valid = 1'b1;
    lat = 0; lat_in = 0; lat_out = 0; res_in = 0; res_out = 0;
    do begin
      step();
      lat++;
      if (in_sample_ready && lat_in == 0) begin
        lat_in = lat;
        res_in = int'(in_sample_out);
        in_sample_valid = 1'b0;
      end
      if (out_sample_ready) begin
        lat_out = lat;
        res_out = int'(out_sample);
      end
    end while (lat_out == 0 && lat < 60);
    out_samples_valid = 1'b0;
    step();
    check("arb_in_lat", lat_in, 3);
    check("arb_in_value", res_in, 800);
    check("arb_out_lat", lat_out, 12);
    check("arb_out_value", res_out, 1200);

    // Reset in the middle of MAC, together with a switch request.
    write_reg(0, 4096);
    write_reg(1, 1024);
    out_samples_in = pack(1000, 2000, 3000, 4000);
    out_samples_valid = 1'b1;
    step();
    step();
    reset = 1'b1;
    switch_req = 1'b1;
    switch_target = 2'd2;
    out_samples_valid = 1'b0;
    step();
    reset = 1'b0;
    switch_req = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_sample_ready) seen++;
      step();
    end
    check("mac_reset_no_ready", seen, 0);
    check("mac_reset_out_sample", int'(out_sample), 0);
    check("mac_reset_switching", switching, 0);
    check("mac_reset_current", current_pipeline, 0);
    run_out(pack(1000, 2000, 3000, 4000), res, lat);
    check("post_reset_out", res, 1000);
    run_in(1000, res, lat);
    check("post_reset_in", res, 1000);

    // Default ramp step after reset is 16: 64 samples reach the midpoint.
    request(1);
    step();
    feed(64);
    check("default_step_switching", switching, 1);
    run_out(pack(2000, 4000, 0, 0), res, lat);
    check("default_step_mix", res, 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
